// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: widths and FSM state encoding.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the HI/LO stall logic (master) and the divider (slave).
interface div_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;

  modport master (
    output start, is_signed, dividend, divisor,
    input  q, r, busy, done
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output q, r, busy, done
  );

endinterface

// File: rtl/divu_iter.sv
// Unsigned restoring division core: one quotient bit per step, plus iteration counter.
// Optional early exit when the quotient is trivially zero is enabled by DIV_FAST_EN.
module divu_iter
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             last
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             early;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
`ifdef DIV_FAST_EN
    // Decided on the first step from latched magnitudes; quo_q still holds |a| here.
    early = (cnt_q == CNT_W'(WIDTH - 1)) && ((b_q == '0) || (quo_q < b_q));
`else
    early = 1'b0;
`endif
    last  = early || (cnt_q == '0);

    quo_d = quo_q;
    rem_d = rem_q;
    b_d   = b_q;
    cnt_d = cnt_q;

    if (load) begin
      quo_d = a_mag;
      rem_d = '0;
      b_d   = b_mag;
      cnt_d = CNT_W'(WIDTH - 1);
    end else if (step) begin
      if (early) begin
        rem_d = quo_q;
        quo_d = '0;
        cnt_d = '0;
      end else begin
        // trial[WIDTH] is the sign of the (WIDTH+1)-bit difference
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign quo = quo_q;
  assign rem = rem_q;

endmodule

// File: rtl/div_iter.sv
// Signed/unsigned iterative divider (DIV/DIVU): sign handling around the divu_iter core.
// Build option DIV_FAST_EN (in divu_iter) shortens trivial divisions to two clocks.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic reset,
  div_if.slave bus
);

  div_state_e       state_q, state_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             bz_q, bz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] quo, rem;
  logic             a_neg, b_neg;
  logic             accept;
  logic             core_step;
  logic             core_last;

  always_comb begin
    a_neg  = bus.is_signed && bus.dividend[WIDTH-1];
    b_neg  = bus.is_signed && bus.divisor[WIDTH-1];
    a_mag  = a_neg ? -bus.dividend : bus.dividend;
    b_mag  = b_neg ? -bus.divisor  : bus.divisor;
    accept = bus.start && (state_q == ST_IDLE);

    state_d   = state_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    bz_d      = bz_q;
    q_d       = q_q;
    r_d       = r_q;
    done_d    = 1'b0;
    core_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CALC;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          bz_d    = (bus.divisor == '0);
        end
      end
      ST_CALC: begin
        core_step = 1'b1;
        if (core_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        // Divide by zero yields all ones regardless of operand signs
        q_d     = bz_q ? '1 : (neg_q_q ? -quo : quo);
        r_d     = neg_r_q ? -rem : rem;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      bz_q    <= bz_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  divu_iter #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .step  (core_step),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .quo   (quo),
    .rem   (rem),
    .last  (core_last)
  );

  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed and small randomised checks of div_iter results, latency and handshake.
module tb_div_iter;
  import div_pkg::*;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        fast;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[12];

  div_if #(.WIDTH(DIV_WIDTH)) bus ();

  div_iter #(
    .WIDTH(DIV_WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic fast);
`ifdef DIV_FAST_EN
    return fast ? 2 : 33;
`else
    return 33;
`endif
  endfunction

  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // poke_at >= 0 drives a spurious start with different operands while busy
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic fast,
                        input int poke_at, input string tag);
    int lat;
    int bcyc;
    launch(sgn, a, b);
    lat  = 0;
    bcyc = bus.busy ? 1 : 0;
    while (lat < 100) begin
      if (lat == poke_at) begin
        bus.start     = 1'b1;
        bus.is_signed = ~sgn;
        bus.dividend  = 32'h0000_DEAD;
        bus.divisor   = 32'h0000_0003;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
      if (bus.done) break;
      if (bus.busy) bcyc++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(fast)));
    check({tag, "_busycyc"}, 32'(bcyc), 32'(exp_lat(fast)));
    check({tag, "_q"}, bus.q, eq);
    check({tag, "_r"}, bus.r, er);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, ma, mb, eq, er;
    logic        rs;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
    vecs[5]  = '{1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0};
    vecs[6]  = '{1'b1, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vecs[7]  = '{1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vecs[8]  = '{1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         1'b1};
    vecs[9]  = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1};
    vecs[11] = '{1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFD, 1'b1};

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    reset         = 1'b1;
    #12;
    check("rst_q", bus.q, 32'd0);
    check("rst_r", bus.r, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].fast, -1,
             $sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
      @(negedge clk);
    end

    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 5, "poke");
    @(negedge clk);

    // Second launch happens in the done cycle of the first
    run_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, -1, "b2b_a");
    run_op(1'b0, 32'd9999, 32'd100, 32'd99, 32'd99, 1'b0, -1, "b2b_b");
    @(negedge clk);

    launch(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_q", bus.q, 32'd0);
    check("midrst_r", bus.r, 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, -1, "post_rst");
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = (i % 2 == 1);
      if (i % 4 == 0) rb = rb >> 20;
      if (i % 5 == 0) ra = ra >> 28;
      if (rb == 32'd0) rb = 32'd1;
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd2;
      if (rs) begin
        eq = $signed(ra) / $signed(rb);
        er = $signed(ra) % $signed(rb);
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      ma = (rs && ra[31]) ? -ra : ra;
      mb = (rs && rb[31]) ? -rb : rb;
      run_op(rs, ra, rb, eq, er, (ma < mb), -1, $sformatf("rnd%0d", i));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
